// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : wb_regfile
//  Description : Writeback stage and architectural register file. Commits
//                ME->WB results to the GPRs, serves two combinational read
//                ports with a write-first bypass, a registered debug read
//                port, and the retire/cycle counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int CNT_W      = 64,
    parameter int RESET_REGS = 1
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iEn,
    input  logic              iStall,
    input  logic              iFlush,
    input  logic              iWbValid,
    input  logic              iWbWe,
    input  logic [ADDR_W-1:0] iWbAddr,
    input  logic [DATA_W-1:0] iWbData,
    input  logic [ADDR_W-1:0] iAddrRs1,
    input  logic [ADDR_W-1:0] iAddrRs2,
    output logic [DATA_W-1:0] oRs1,
    output logic [DATA_W-1:0] oRs2,
    input  logic [ADDR_W-1:0] iDbgAddr,
    output logic [DATA_W-1:0] oDbgData,
    output logic              oRetired,
    output logic [CNT_W-1:0]  oInstret,
    output logic [CNT_W-1:0]  oCycle
);

    localparam int c_NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [c_NUM_REGS];
    logic [DATA_W-1:0] r_dbg_data;
    logic [CNT_W-1:0]  r_instret;
    logic [CNT_W-1:0]  r_cycle;
    logic              r_retired;
    logic              w_commit;
    logic              w_write;

    // Reset discards whatever sits at the WB input, so it also blocks commit
    // (and therefore the bypass) on a reset cycle.
    assign w_commit = ~iRst & iEn & ~iStall & ~iFlush & iWbValid;
    assign w_write  = w_commit & iWbWe & (iWbAddr != '0);

    // Register storage; x0 is never written, reads of it are forced to zero.
    generate
        if (RESET_REGS != 0) begin : g_regs_reset
            // Clear the whole file on reset, otherwise commit the WB result.
            always_ff @(posedge iClk) begin
                if (iRst) begin
                    for (int i = 0; i < c_NUM_REGS; i++) begin
                        r_regs[i] <= '0;
                    end
                end else if (w_write) begin
                    r_regs[iWbAddr] <= iWbData;
                end
            end
        end else begin : g_regs_hold
            // Contents survive reset; only the commit path updates them.
            always_ff @(posedge iClk) begin
                if (w_write) begin
                    r_regs[iWbAddr] <= iWbData;
                end
            end
        end
    endgenerate

    // Read port 1: x0 is zero, then same-cycle bypass, then stored value.
    always_comb begin
        oRs1 = r_regs[iAddrRs1];
        if (iAddrRs1 == '0) begin
            oRs1 = '0;
        end else if (w_write && (iAddrRs1 == iWbAddr)) begin
            oRs1 = iWbData;
        end
    end

    // Read port 2: identical to port 1, bypasses independently.
    always_comb begin
        oRs2 = r_regs[iAddrRs2];
        if (iAddrRs2 == '0) begin
            oRs2 = '0;
        end else if (w_write && (iAddrRs2 == iWbAddr)) begin
            oRs2 = iWbData;
        end
    end

    // Counters, retire pulse and debug read; everything freezes when iEn is low.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_instret  <= '0;
            r_cycle    <= '0;
            r_retired  <= 1'b0;
            r_dbg_data <= '0;
        end else if (iEn) begin
            r_cycle   <= r_cycle + CNT_W'(1);
            r_retired <= w_commit;
            if (w_commit) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            // Debug read samples stored state only (no bypass).
            r_dbg_data <= (iDbgAddr == '0) ? '0 : r_regs[iDbgAddr];
        end
    end

    assign oDbgData = r_dbg_data;
    assign oRetired = r_retired;
    assign oInstret = r_instret;
    assign oCycle   = r_cycle;

endmodule
`default_nettype wire
